// File: rtl/ddc_chan_rx.sv
// Single-channel DDC: NCO mix of a real stream to I/Q, accumulate-and-dump by DEC, round/saturate to DOUT_W.
// Output valid 3 cycles after the last sample of a frame; no backpressure, input is strobed by ce_1.
module ddc_chan_rx #(
  parameter int DIN_W   = 14,
  parameter int DOUT_W  = 16,
  parameter int PHASE_W = 10,
  parameter int DEC     = 8
) (
  input  logic                      clk_1,
  input  logic                      rst,
  input  logic                      ce_1,
  input  logic signed [DIN_W-1:0]   din,
  input  logic [PHASE_W-1:0]        freq_word,
  input  logic [1:0]                gain,
  input  logic                      ena,
  input  logic                      ovf_clr,
  output logic signed [DOUT_W-1:0]  iout,
  output logic signed [DOUT_W-1:0]  qout,
  output logic                      dout_vld,
  output logic                      ovf
);
  localparam int  LG_DEC = $clog2(DEC);
  localparam int  PROD_W = DIN_W + 16;
  localparam int  ACC_W  = PROD_W + LG_DEC;
  localparam int  QTR    = 2 ** (PHASE_W - 2);
  localparam int  IDX_W  = PHASE_W - 1;
  localparam real PI     = 3.14159265358979323846;
  localparam logic signed [ACC_W:0] YMAX = (ACC_W+1)'(2 ** (DOUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] YMIN = (ACC_W+1)'(-(2 ** (DOUT_W - 1)));

  function automatic logic [15:0] qwave(input int k);
    real r;
    r = 32767.0 * $cos(2.0 * PI * real'(k) / real'(4 * QTR));
    return 16'($rtoi(r + 0.5));
  endfunction

  // Quarter-wave cosine table, entries 0..QTR inclusive so both quadrant mirrors index it directly.
  logic [15:0] qlut [0:QTR];
  for (genvar k = 0; k <= QTR; k++) begin : g_lut
    localparam logic [15:0] QV = qwave(k);
    assign qlut[k] = QV;
  end

  logic [PHASE_W-1:0]       phase_acc, inc_reg, inc_eff, p_sin;
  logic [LG_DEC-1:0]        cnt;
  logic signed [ACC_W-1:0]  acc_i, acc_q, sum_i, sum_q;
  logic signed [ACC_W:0]    half, rnd_i, rnd_q, y_i, y_q;
  logic [IDX_W-1:0]         cos_idx, sin_idx;
  logic signed [15:0]       cos_val, sin_val;
  logic signed [PROD_W-1:0] mi, mq;
  logic [ACC_W-1:0]         mi_ext, mq_ext;
  logic [5:0]               shamt;
  logic                     vld1, vld2, hi_i, lo_i, hi_q, lo_q;
  logic                     last;

  // sin(p) is read from the cosine table a quarter turn earlier.
  assign p_sin = phase_acc - PHASE_W'(QTR);

  always_comb begin
    cos_idx = phase_acc[PHASE_W-2] ? IDX_W'(QTR) - {1'b0, phase_acc[PHASE_W-3:0]}
                                   : {1'b0, phase_acc[PHASE_W-3:0]};
    sin_idx = p_sin[PHASE_W-2] ? IDX_W'(QTR) - {1'b0, p_sin[PHASE_W-3:0]}
                               : {1'b0, p_sin[PHASE_W-3:0]};
    cos_val = $signed(qlut[cos_idx]);
    sin_val = $signed(qlut[sin_idx]);
    if (phase_acc[PHASE_W-1] ^ phase_acc[PHASE_W-2]) cos_val = -cos_val;
    if (p_sin[PHASE_W-1] ^ p_sin[PHASE_W-2])         sin_val = -sin_val;
  end

  assign mi     = din * cos_val;
  assign mq     = -(din * sin_val);
  assign mi_ext = {{LG_DEC{mi[PROD_W-1]}}, mi};
  assign mq_ext = {{LG_DEC{mq[PROD_W-1]}}, mq};

  // A new frame picks up freq_word immediately, so its own second sample already steps by it.
  assign inc_eff = (cnt == '0) ? freq_word : inc_reg;
  assign last    = (cnt == LG_DEC'(DEC - 1));

  assign shamt = 6'(DIN_W + LG_DEC) - {4'b0, gain};
  assign half  = (ACC_W+1)'(1) << (shamt - 6'd1);
  assign rnd_i = {sum_i[ACC_W-1], sum_i} + half;
  assign rnd_q = {sum_q[ACC_W-1], sum_q} + half;

  assign hi_i = (y_i > YMAX);
  assign lo_i = (y_i < YMIN);
  assign hi_q = (y_q > YMAX);
  assign lo_q = (y_q < YMIN);

  always_ff @(posedge clk_1) begin
    if (rst) begin
      phase_acc <= '0;
      inc_reg   <= '0;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sum_i     <= '0;
      sum_q     <= '0;
      y_i       <= '0;
      y_q       <= '0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      dout_vld  <= 1'b0;
      iout      <= '0;
      qout      <= '0;
      ovf       <= 1'b0;
    end else begin
      vld1 <= 1'b0;
      if (!ena) begin
        phase_acc <= '0;
        cnt       <= '0;
        acc_i     <= '0;
        acc_q     <= '0;
      end else if (ce_1) begin
        phase_acc <= phase_acc + inc_eff;
        if (cnt == '0) inc_reg <= freq_word;
        if (last) begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
          sum_i <= acc_i + mi_ext;
          sum_q <= acc_q + mq_ext;
          vld1  <= 1'b1;
        end else begin
          cnt   <= cnt + LG_DEC'(1);
          acc_i <= acc_i + mi_ext;
          acc_q <= acc_q + mq_ext;
        end
      end

      vld2 <= vld1;
      y_i  <= rnd_i >>> shamt;
      y_q  <= rnd_q >>> shamt;

      dout_vld <= vld2;
      if (vld2) begin
        iout <= hi_i ? YMAX[DOUT_W-1:0] : lo_i ? YMIN[DOUT_W-1:0] : y_i[DOUT_W-1:0];
        qout <= hi_q ? YMAX[DOUT_W-1:0] : lo_q ? YMIN[DOUT_W-1:0] : y_q[DOUT_W-1:0];
      end
      // A fresh saturation wins over a simultaneous clear.
      ovf <= (vld2 & (hi_i | lo_i | hi_q | lo_q)) | (ovf & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_ddc_chan_rx.sv
// Directed bench for ddc_chan_rx: a real-arithmetic model predicts every output cycle,
// and hand-computed values pin the model on the key vectors.
module tb_ddc_chan_rx;
  localparam real PI = 3.14159265358979323846;

  logic               clk_1 = 1'b0;
  logic               rst = 1'b1;
  logic               ce_1 = 1'b0;
  logic signed [13:0] din = '0;
  logic [9:0]         freq_word = '0;
  logic [1:0]         gain = '0;
  logic               ena = 1'b0;
  logic               ovf_clr = 1'b0;
  logic signed [15:0] iout, qout;
  logic               dout_vld, ovf;

  int vectors = 0;
  int miscompares = 0;
  int vld_cnt = 0;

  ddc_chan_rx #(.DIN_W(14), .DOUT_W(16), .PHASE_W(10), .DEC(8)) dut (
    .clk_1(clk_1), .rst(rst), .ce_1(ce_1), .din(din), .freq_word(freq_word),
    .gain(gain), .ena(ena), .ovf_clr(ovf_clr), .iout(iout), .qout(qout),
    .dout_vld(dout_vld), .ovf(ovf)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint si; longint sq; longint yi; longint yq; bit sat; int due;
  } ent_t;

  ent_t   pend[$];
  int     cyc = 0;
  bit     chk_en = 0;
  int     m_phase, m_inc, m_cnt;
  longint m_acci, m_accq;
  bit     m_vld, m_ovf;
  longint m_i, m_q;

  function automatic longint rnd_real(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  function automatic longint rcos(input int p);
    return rnd_real(32767.0 * $cos(2.0 * PI * real'(p) / 1024.0));
  endfunction

  function automatic longint rsin(input int p);
    return rnd_real(32767.0 * $sin(2.0 * PI * real'(p) / 1024.0));
  endfunction

  function automatic void scale(input longint s, input int g, output longint y, output bit st);
    int sh;
    sh = 17 - g;
    y  = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    st = 1'b0;
    if (y > 32767) begin y = 32767; st = 1'b1; end
    else if (y < -32768) begin y = -32768; st = 1'b1; end
  endfunction

  always @(posedge clk_1) begin : model
    ent_t   e;
    bit     es, s1, s2;
    longint y1, y2, d;
    cyc++;
    if (rst) begin
      pend.delete();
      m_vld = 0; m_i = 0; m_q = 0; m_ovf = 0;
      m_phase = 0; m_inc = 0; m_cnt = 0; m_acci = 0; m_accq = 0;
    end else begin
      es = 0;
      m_vld = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_vld = 1; m_i = pend[0].yi; m_q = pend[0].yq; es = pend[0].sat;
        void'(pend.pop_front());
      end
      m_ovf = es || (m_ovf && !ovf_clr);
      foreach (pend[k]) begin
        if (pend[k].due == cyc + 1) begin
          scale(pend[k].si, int'(gain), y1, s1);
          scale(pend[k].sq, int'(gain), y2, s2);
          pend[k].yi = y1; pend[k].yq = y2; pend[k].sat = s1 | s2;
        end
      end
      if (!ena) begin
        m_phase = 0; m_cnt = 0; m_acci = 0; m_accq = 0;
      end else if (ce_1) begin
        d = longint'(din);
        if (m_cnt == 0) m_inc = int'(freq_word);
        m_acci += d * rcos(m_phase);
        m_accq -= d * rsin(m_phase);
        m_phase = (m_phase + m_inc) % 1024;
        m_cnt++;
        if (m_cnt == 8) begin
          e.si = m_acci; e.sq = m_accq; e.yi = 0; e.yq = 0; e.sat = 0; e.due = cyc + 2;
          pend.push_back(e);
          m_cnt = 0; m_acci = 0; m_accq = 0;
        end
      end
    end
    chk_en = 1;
  end

  always @(negedge clk_1) begin
    if (chk_en) begin
      chk("dout_vld", longint'(dout_vld), longint'(m_vld));
      chk("ovf", longint'(ovf), longint'(m_ovf));
      chk("iout", longint'(iout), m_i);
      chk("qout", longint'(qout), m_q);
      if (dout_vld) vld_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input int d);
    @(negedge clk_1);
    ce_1 = 1'b1;
    din  = 14'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_1);
      ce_1 = 1'b0;
    end
  endtask

  task automatic clear_chan();
    @(negedge clk_1);
    ce_1 = 1'b0; ena = 1'b0;
    @(negedge clk_1);
    ena = 1'b1;
  endtask

  task automatic run_frame(input int d0, input int d1, input int d2, input int d3, input int gapmax);
    int pat[4];
    pat = '{d0, d1, d2, d3};
    for (int i = 0; i < 8; i++) begin
      if (gapmax > 0 && i > 0) idle(int'($urandom_range(0, gapmax)));
      strobe(pat[i % 4]);
    end
  endtask

  task automatic expect_out(input string nm, input longint ei, input longint eq);
    int n;
    n = 0;
    do begin
      @(negedge clk_1);
      ce_1 = 1'b0;
      n++;
    end while (!dout_vld && n < 8);
    chk({nm, " latency"}, n, 3);
    chk({nm, " iout"}, longint'(iout), ei);
    chk({nm, " qout"}, longint'(qout), eq);
  endtask

  initial begin
    int v0;
    // 1: reset held with random inputs
    repeat (5) begin
      @(negedge clk_1);
      ce_1 = 1'($urandom); ena = 1'($urandom); din = 14'($urandom);
      freq_word = 10'($urandom); gain = 2'($urandom); ovf_clr = 1'($urandom);
    end
    @(negedge clk_1);
    chk("rst iout", longint'(iout), 0);
    chk("rst qout", longint'(qout), 0);
    chk("rst dout_vld", longint'(dout_vld), 0);
    chk("rst ovf", longint'(ovf), 0);
    rst = 1'b0; ce_1 = 1'b0; ena = 1'b1; din = '0;
    freq_word = '0; gain = 2'd0; ovf_clr = 1'b0;

    // 2: DC through cos(0)
    run_frame(4096, 4096, 4096, 4096, 0);
    expect_out("dc", 8192, 0);

    // 3: fs/4 mixing
    freq_word = 10'd256;
    clear_chan();
    run_frame(4096, 0, -4096, 0, 0);
    expect_out("fs4", 4096, 0);

    // gain steps and negative input: exact rounding boundaries
    freq_word = '0;
    clear_chan();
    gain = 2'd1;
    run_frame(4096, 4096, 4096, 4096, 0);
    expect_out("gain1", 16384, 0);
    gain = 2'd2;
    run_frame(4096, 4096, 4096, 4096, 0);
    expect_out("gain2", 32767, 0);
    chk("gain2 ovf", longint'(ovf), 0);
    gain = 2'd0;
    run_frame(-4096, -4096, -4096, -4096, 0);
    expect_out("neg", -8192, 0);

    // 4: saturation and sticky ovf
    gain = 2'd3;
    run_frame(4096, 4096, 4096, 4096, 0);
    expect_out("sat_pos", 32767, 0);
    chk("sat ovf set", longint'(ovf), 1);
    @(negedge clk_1); ovf_clr = 1'b1;
    @(negedge clk_1); ovf_clr = 1'b0;
    chk("ovf cleared", longint'(ovf), 0);
    gain = 2'd2;
    ovf_clr = 1'b1;
    run_frame(-8192, -8192, -8192, -8192, 0);
    expect_out("sat_neg", -32768, 0);
    chk("ovf set wins", longint'(ovf), 1);
    @(negedge clk_1); ovf_clr = 1'b0;
    chk("ovf clr after", longint'(ovf), 0);
    gain = 2'd0;

    // 5: ena drop discards a partial frame
    v0 = vld_cnt;
    repeat (5) strobe(4096);
    clear_chan();
    run_frame(4096, 4096, 4096, 4096, 0);
    expect_out("ena_drop", 8192, 0);
    idle(4);
    chk("ena_drop pulses", vld_cnt - v0, 1);

    // 6: random ce_1 gaps give identical results
    for (int f = 0; f < 3; f++) begin
      run_frame(4096, 4096, 4096, 4096, 4);
      expect_out("gaps", 8192, 0);
    end

    // arbitrary tone with phase carried across frames and a freq change
    freq_word = 10'd37;
    clear_chan();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        if (f == 1 && i == 3) freq_word = 10'd611;
        strobe(int'($urandom_range(0, 16383)) - 8192);
      end
    end
    idle(6);

    // rst mid-frame aborts the frame
    v0 = vld_cnt;
    repeat (6) strobe(4096);
    @(negedge clk_1); ce_1 = 1'b0; rst = 1'b1;
    @(negedge clk_1); rst = 1'b0;
    idle(6);
    chk("rst abort pulses", vld_cnt - v0, 0);
    chk("rst abort iout", longint'(iout), 0);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end
endmodule
